hamming_scrubber: RTL and testbench

- Background ECC scrubber for the banked memory that stores Hamming(12,8) codewords.
- On command, it walks the bank address range through an arbitrated memory port and reads each codeword.
- It computes the syndrome, writes back a corrected codeword on any single-bit error, and counts corrected and uncorrectable words.
- It sits beside the functional encode/decode path, on the memory side, and yields to functional traffic through a req/gnt handshake.

---
 rtl/hamming_scrubber_pkg.sv | 21 ++
 rtl/hamming12_syndrome.sv | 21 ++
 rtl/hamming_scrubber.sv | 119 +++++++++++
 tb/tb_hamming_scrubber.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_scrubber_pkg.sv
// Shared Hamming(12,8) constants and scrubber state encoding.
package hamming_pkg;
  localparam int CW_W   = 12;
  localparam int DATA_W = 8;

  // Parity coverage: bit i set when Hamming position i+1 contributes to that check
  localparam logic [CW_W-1:0] P1 = 12'h555;
  localparam logic [CW_W-1:0] P2 = 12'h666;
  localparam logic [CW_W-1:0] P4 = 12'h878;
  localparam logic [CW_W-1:0] P8 = 12'hF80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR_REQ,
    S_NEXT,
    S_DONE
  } scrub_state_e;
endpackage

// File: rtl/hamming12_syndrome.sv
// Combinational Hamming(12,8) syndrome with single-error correction.
module hamming12_syndrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [3:0]      syn_o,
  output logic [CW_W-1:0] corr_o,
  output logic            corr_vld_o,
  output logic            uncorr_o
);
  assign syn_o = {^(cw_i & P8), ^(cw_i & P4), ^(cw_i & P2), ^(cw_i & P1)};

  // Syndromes 13..15 name positions that do not exist in a 12-bit word
  assign uncorr_o   = syn_o[3] & syn_o[2] & (syn_o[1] | syn_o[0]);
  assign corr_vld_o = (syn_o != 4'd0) && !uncorr_o;

  always_comb begin
    corr_o = cw_i;
    if (corr_vld_o) corr_o = cw_i ^ (CW_W'(1) << (syn_o - 4'd1));
  end
endmodule

// File: rtl/hamming_scrubber.sv
// Background scrubber: walks DEPTH codewords, writes back single-bit fixes, counts errors.
module hamming_scrubber
  import hamming_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [CW_W-1:0]   o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic [CW_W-1:0]   i_mem_rdata,
  output logic [CNT_W-1:0]  o_corr_cnt,
  output logic [CNT_W-1:0]  o_uncorr_cnt,
  output logic [ADDR_W-1:0] o_err_addr
);
  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CW_W-1:0]   rdata_q, rdata_d;
  logic [CW_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;

  logic [3:0]        syn;
  logic [CW_W-1:0]   fixed;
  logic              fix_vld, bad;

  hamming12_syndrome u_syn (
    .cw_i       (rdata_q),
    .syn_o      (syn),
    .corr_o     (fixed),
    .corr_vld_o (fix_vld),
    .uncorr_o   (bad)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      err_addr_q <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      corr_q     <= '0;
      uncorr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_addr_d = err_addr_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        corr_d   = '0;
        uncorr_d = '0;
        addr_d   = '0;
        state_d  = S_RD_REQ;
      end
      S_RD_REQ:  if (i_mem_gnt) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rdata_d = i_mem_rdata;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_NEXT;
        if (fix_vld) begin
          wdata_d    = fixed;
          err_addr_d = addr_q;
          if (corr_q != {CNT_W{1'b1}}) corr_d = corr_q + 1'b1;
          state_d    = S_WR_REQ;
        end else if (bad) begin
          err_addr_d = addr_q;
          if (uncorr_q != {CNT_W{1'b1}}) uncorr_d = uncorr_q + 1'b1;
        end
      end
      S_WR_REQ: if (i_mem_gnt) state_d = S_NEXT;
      S_NEXT: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) state_d = S_DONE;
        else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request outputs decode straight from state so an async reset drops req at once
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_mem_req    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign o_mem_we     = (state_q == S_WR_REQ);
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_corr_cnt   = corr_q;
  assign o_uncorr_cnt = uncorr_q;
  assign o_err_addr   = err_addr_q;
endmodule

// File: tb/tb_hamming_scrubber.sv
// Bench for hamming_scrubber: transaction-level model, per-cycle port checks, directed passes.
module tb_hamming_scrubber;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [11:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // primary DUT (CNT_W=8) with stallable grant
  logic start = 1'b0, gnt = 1'b1;
  logic busy, done, req, we;
  logic [3:0] addr, err_addr;
  logic [11:0] wdata, rdata;
  logic [7:0] corr, uncorr;

  // saturation DUT (CNT_W=2), grant tied high
  logic start2 = 1'b0;
  logic busy2, done2, req2, we2;
  logic [3:0] addr2, err_addr2;
  logic [11:0] wdata2, rdata2;
  logic [1:0] corr2, uncorr2;

  hamming_scrubber #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_mem_req(req), .o_mem_we(we), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .i_mem_gnt(gnt), .i_mem_rdata(rdata), .o_corr_cnt(corr), .o_uncorr_cnt(uncorr),
    .o_err_addr(err_addr));

  hamming_scrubber #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
    .o_mem_req(req2), .o_mem_we(we2), .o_mem_addr(addr2), .o_mem_wdata(wdata2),
    .i_mem_gnt(1'b1), .i_mem_rdata(rdata2), .o_corr_cnt(corr2), .o_uncorr_cnt(uncorr2),
    .o_err_addr(err_addr2));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // memories: all writes in one process, images loaded through load/load2
  logic [11:0] mem [DEPTH], img [DEPTH], mem2 [DEPTH], img2 [DEPTH];
  logic load = 1'b0, load2 = 1'b0;
  always @(posedge clk) begin
    if (load) for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
    else if (req && gnt) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
    if (load2) for (int i = 0; i < DEPTH; i++) mem2[i] <= img2[i];
    else if (req2) begin
      if (we2) mem2[addr2] <= wdata2;
      else rdata2 <= mem2[addr2];
    end
  end

  // grant stalls: 7 cycles on the read of addr 3 and on the write of addr 5
  logic stall_en = 1'b0;
  int st_rd = 0, st_wr = 0;
  always @(posedge clk) begin
    #2;
    if (!stall_en) begin st_rd = 0; st_wr = 0; gnt = 1'b1; end
    else if (req && !we && addr == 4'd3 && st_rd < 7) begin gnt = 1'b0; st_rd++; end
    else if (req && we && addr == 4'd5 && st_wr < 7) begin gnt = 1'b0; st_wr++; end
    else gnt = 1'b1;
  end

  // ---------------- model ----------------
  // syndrome as XOR of the positions of all set bits
  function automatic logic [3:0] msyn(input logic [11:0] c);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 12; i++) if (c[i]) s ^= 4'(i + 1);
    return s;
  endfunction

  acc_t exp_q[$];
  logic [11:0] pimg [DEPTH], pmem [DEPTH];
  int p_corr, p_uncorr, p_cyc;
  int exp_corr = 0, exp_uncorr = 0, m_ea = 0;

  task automatic plan(input int cmax, input bit push, inout int ea);
    logic [3:0] s;
    logic [11:0] w;
    acc_t t;
    p_corr = 0; p_uncorr = 0; p_cyc = 0;
    for (int a = 0; a < DEPTH; a++) begin
      w = pimg[a];
      s = msyn(w);
      pmem[a] = w;
      p_cyc += 4;
      t.we = 1'b0; t.addr = 4'(a); t.wdata = 12'h0;
      if (push) exp_q.push_back(t);
      if (s >= 4'd1 && s <= 4'd12) begin
        pmem[a] = w ^ (12'h1 << (s - 4'd1));
        t.we = 1'b1; t.wdata = pmem[a];
        if (push) exp_q.push_back(t);
        p_corr = (p_corr + 1 > cmax) ? cmax : p_corr + 1;
        ea = a;
        p_cyc += 1;
      end else if (s >= 4'd13) begin
        p_uncorr = (p_uncorr + 1 > cmax) ? cmax : p_uncorr + 1;
        ea = a;
      end
    end
  endtask

  // ---------------- per-cycle compare (primary DUT) ----------------
  logic prev_pend = 1'b0;
  acc_t prev_acc, cur, e;
  always @(negedge clk) begin
    if (!rst_n) prev_pend = 1'b0;
    else begin
      cur.we = we; cur.addr = addr; cur.wdata = wdata;
      if (prev_pend) begin
        chk("hold_req", 32'(req), 32'd1);
        chk("hold_acc", 32'(cur), 32'(prev_acc));
      end
      if (req === 1'b1 && gnt === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_access", 32'(cur), 32'h1ffff);
        else begin
          e = exp_q.pop_front();
          chk("acc_we", 32'(we), 32'(e.we));
          chk("acc_addr", 32'(addr), 32'(e.addr));
          if (e.we) chk("acc_wdata", 32'(wdata), 32'(e.wdata));
        end
      end
      if (done === 1'b1) begin
        chk("done_corr", 32'(corr), 32'(exp_corr));
        chk("done_uncorr", 32'(uncorr), 32'(exp_uncorr));
        chk("done_err_addr", 32'(err_addr), 32'(m_ea));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
      end
      prev_pend = (req === 1'b1) && (gnt !== 1'b1);
      prev_acc  = cur;
    end
  end

  // ---------------- directed passes ----------------
  task automatic fill_clean();
    for (int i = 0; i < DEPTH; i++) img[i] = 12'hA27;
  endtask

  task automatic run_pass(output int lat);
    int n = 0, bad = 0;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    for (int i = 0; i < DEPTH; i++) pimg[i] = img[i];
    plan(255, 1'b1, m_ea);
    exp_corr = p_corr; exp_uncorr = p_uncorr;
    start = 1'b1;
    lat = -1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin n = k; break; end
    end
    if (n == 0) chk("done_timeout", 32'd0, 32'd1);
    else begin
      lat = n - 1;
      if (!stall_en) chk("done_latency", 32'(lat), 32'(p_cyc));
    end
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== pmem[i]) bad++;
    chk("mem_image", 32'(bad), 32'd0);
  endtask

  initial begin
    int lat, n, bad;
    // model pins
    chk("model_syn_clean", 32'(msyn(12'hA27)), 32'd0);
    chk("model_syn_pos6", 32'(msyn(12'hA07)), 32'd6);
    chk("model_syn_p1p12", 32'(msyn(12'h226)), 32'd13);

    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_cnts", 32'({corr, uncorr}), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // all clean: no writes, 64-cycle pass
    fill_clean();
    run_pass(lat);
    chk("clean_latency", 32'(lat), 32'd64);
    chk("clean_cnts", 32'({corr, uncorr}), 32'd0);

    // single error at position 6 of address 5
    img[5] = 12'hA07;
    run_pass(lat);
    chk("fix_latency", 32'(lat), 32'd65);
    chk("fix_corr", 32'(corr), 32'd1);
    chk("fix_err_addr", 32'(err_addr), 32'd5);
    chk("fix_mem5", 32'(mem[5]), 32'hA27);

    // double error at address 9 -> syndrome 13, left alone
    fill_clean();
    img[9] = 12'h226;
    run_pass(lat);
    chk("unc_latency", 32'(lat), 32'd64);
    chk("unc_cnt", 32'({corr, uncorr}), 32'd1);
    chk("unc_err_addr", 32'(err_addr), 32'd9);
    chk("unc_mem9", 32'(mem[9]), 32'h226);

    // clean pass keeps err_addr from the previous pass
    fill_clean();
    run_pass(lat);
    chk("keep_err_addr", 32'(err_addr), 32'd9);

    // stalled grant on read of 3 and write of 5
    fill_clean();
    img[5] = 12'hA07;
    stall_en = 1'b1;
    run_pass(lat);
    chk("stall_latency", 32'(lat), 32'd79);
    chk("stall_corr", 32'(corr), 32'd1);
    chk("stall_err_addr", 32'(err_addr), 32'd5);
    chk("stall_mem5", 32'(mem[5]), 32'hA27);
    stall_en = 1'b0;

    // reset during WR_REQ
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    for (int i = 0; i < DEPTH; i++) pimg[i] = img[i];
    plan(255, 1'b1, m_ea);
    start = 1'b1;
    n = 0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (req && we) begin n = k; break; end
    end
    if (n == 0) chk("wr_req_timeout", 32'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_corr", 32'(corr), 32'd0);
    exp_q.delete();
    m_ea = 0;
    @(negedge clk) rst_n = 1'b1;
    chk("rst_mid_mem5", 32'(mem[5]), 32'hA07);
    run_pass(lat);
    chk("rescrub_corr", 32'(corr), 32'd1);
    chk("rescrub_mem5", 32'(mem[5]), 32'hA27);

    // CNT_W=2 saturation, ignored starts while busy and during DONE
    for (int i = 0; i < DEPTH; i++) img2[i] = 12'hA27;
    img2[1] = 12'hA26; img2[4] = 12'hA25; img2[7] = 12'hA2F;
    img2[10] = 12'hB27; img2[14] = 12'h227;
    @(negedge clk) load2 = 1'b1;
    @(negedge clk) load2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) pimg[i] = img2[i];
    n = 0;
    plan(3, 1'b0, n);
    start2 = 1'b1;
    lat = -1;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start2 = (k == 20);
      if (done2) begin lat = k - 1; break; end
    end
    if (lat < 0) chk("sat_timeout", 32'd0, 32'd1);
    chk("sat_latency", 32'(lat), 32'(p_cyc));
    chk("sat_latency_lit", 32'(lat), 32'd69);
    chk("sat_corr_model", 32'(corr2), 32'(p_corr));
    chk("sat_corr_lit", 32'(corr2), 32'd3);
    chk("sat_uncorr", 32'(uncorr2), 32'd0);
    chk("sat_err_addr", 32'(err_addr2), 32'(n));
    start2 = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy2), 32'd0);
    start2 = 1'b0;
    @(negedge clk);
    chk("sat_cnt_hold", 32'(corr2), 32'd3);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem2[i] !== pmem[i]) bad++;
    chk("sat_mem_image", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
